fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: data bits per frame, equal to the upstream FIFO DATA_WIDTH.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range >= 2.
REQ-003 The block SHALL have parameter STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: upstream FIFO empty flag.
REQ-007 The block SHALL have port fifo_r_data, input, DATA_WIDTH bits: upstream FIFO head word, valid whenever fifo_empty=0 (first-word-fall-through).
REQ-008 The block SHALL have port fifo_rd, output, 1 bit: pop strobe to the upstream FIFO rd input.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-011 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-012 The block SHALL implement FSM states IDLE, START, DATA, STOP, held in a state register.
REQ-013 fifo_rd SHALL be combinational: 1 iff state=IDLE and fifo_empty=0 and reset=0; otherwise 0.
REQ-014 On a posedge with fifo_rd=1, the block SHALL load fifo_r_data into the shift register, clear the bit-cycle counter, set tx<=0 and state<=START.
REQ-015 fifo_rd SHALL be high for exactly one cycle per frame; no pop SHALL occur outside IDLE.
REQ-016 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index cleared.
REQ-017 DATA SHALL drive DATA_WIDTH bits LSB first, each held CLKS_PER_BIT cycles; after the last bit, go to STOP.
REQ-018 STOP SHALL hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
REQ-019 tx_done SHALL be registered, high only in the first cycle after STOP ends.
REQ-020 tx SHALL be driven from a register (glitch-free).
REQ-021 tx_busy SHALL be 1 iff state!=IDLE.
REQ-022 The frame length from pop edge to return to IDLE SHALL be (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-023 With a non-empty FIFO, back-to-back frames SHALL pop in the first IDLE cycle, giving exactly one extra tx=1 cycle between frames.
REQ-024 Counter widths SHALL hold STOP_BITS*CLKS_PER_BIT-1 and DATA_WIDTH-1 without overflow; counters SHALL reset to 0 at each state entry.
REQ-025 fifo_empty and fifo_r_data changes outside IDLE SHALL not affect the frame in progress.

Reset
REQ-026 While reset=1, the block SHALL force state=IDLE, tx=1, tx_busy=0, tx_done=0, fifo_rd=0, and counters and shift register to 0, independent of clk.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately (tx=1), with no pop.
REQ-028 After reset deasserts, the first pop SHALL occur on the first posedge with fifo_empty=0.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
REQ-029 The bench SHALL check: reset, fifo_empty=1 for 50 cycles -> tx=1, fifo_rd=0, tx_busy=0 throughout.
REQ-030 The bench SHALL check: single word 0x55 -> one fifo_rd pulse; tx = 0 (4 cycles), then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 (4 cycles); tx_done pulses at cycle 40 after the pop edge.
REQ-031 The bench SHALL check: FIFO holds 0xAA, 0x0F back-to-back -> two pops 41 cycles apart; serial bits 0xAA then 0x0F LSB first; one idle-high cycle between frames.
REQ-032 The bench SHALL check: STOP_BITS=2, word 0xFF -> stop high for 8 cycles; frame 44 cycles; tx_busy high exactly 44 cycles.
REQ-033 The bench SHALL check: reset asserted in DATA bit 3 of 0x33 -> tx=1 and tx_busy=0 immediately; after release with FIFO non-empty, the next word frame starts cleanly.
REQ-034 The bench SHALL check: integration with a 4-deep upstream FIFO, 4 words written while busy -> full asserted, all 4 words transmitted in order, empty=1 at end with no extra pop.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO.
// One frame: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CW = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [BW-1:0]         idx, idx_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  tx_d;
    logic                  done_d;

    assign fifo_rd = (state == IDLE) && !fifo_empty && !reset;
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            shreg   <= shreg_d;
            tx      <= tx_d;
            tx_done <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        tx_d    = tx;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (fifo_rd) begin
                    shreg_d = fifo_r_data;
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    tx_d    = shreg[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (idx == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // shift so the next bit is always at position 0
                        idx_d   = idx + 1'b1;
                        shreg_d = shreg >> 1;
                        tx_d    = shreg_d[0];
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == STOP_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO-fed instance with a frame scoreboard,
// plus a two-stop-bit instance driven directly.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst;
    logic       frst;
    logic       wr;
    logic [7:0] wdata;

    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       done;

    logic       empty2;
    logic [7:0] data2;
    logic       rd2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int npops = 0;
    int npush = 0;

    logic [7:0] exp_q[$];
    int         pop_q[$];
    bit         in_frame = 0;

    fifo_uart_tx #(
        .DATA_WIDTH(8),
        .CLKS_PER_BIT(4),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .reset(rst),
        .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data),
        .fifo_rd(fifo_rd),
        .tx(tx),
        .tx_busy(busy),
        .tx_done(done)
    );

    fifo_uart_tx #(
        .DATA_WIDTH(8),
        .CLKS_PER_BIT(4),
        .STOP_BITS(2)
    ) dut2 (
        .clk(clk),
        .reset(rst),
        .fifo_empty(empty2),
        .fifo_r_data(data2),
        .fifo_rd(rd2),
        .tx(tx2),
        .tx_busy(busy2),
        .tx_done(done2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // 4-deep first-word-fall-through upstream FIFO
    logic [7:0] fmem[4];
    logic [2:0] fwp, frp, fcnt;
    logic       ffull;
    logic       fw, fr;
    assign fifo_empty  = (fcnt == 3'd0);
    assign ffull       = (fcnt == 3'd4);
    assign fifo_r_data = fmem[frp[1:0]];
    assign fw = wr && !ffull;
    assign fr = fifo_rd && !fifo_empty;

    always @(posedge clk or posedge frst) begin
        if (frst) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
            for (int i = 0; i < 4; i++) fmem[i] <= '0;
        end else begin
            if (fw) begin
                fmem[fwp[1:0]] <= wdata;
                fwp <= fwp + 3'd1;
            end
            if (fr) frp <= frp + 3'd1;
            fcnt <= fcnt + 3'(fw) - 3'(fr);
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1;
        wdata = d;
        exp_q.push_back(d);
        npush++;
        @(posedge clk);
        #1;
        wr = 0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !in_frame &&
                fifo_empty && !busy) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    // Monitor: cycle-accurate frame checker and serial decoder
    initial begin
        int         m;
        bit         ended;
        logic [7:0] cur;
        logic [7:0] rx;
        logic       etx;
        m = 0;
        cur = '0;
        rx = '0;
        forever begin
            @(negedge clk);
            ended = 0;
            if (rst) begin
                in_frame = 0;
            end else begin
                if (in_frame) begin
                    etx = (m < 4) ? 1'b0 :
                          (m < 36) ? cur[(m-4)/4] : 1'b1;
                    chk("frame_cycle",
                        {28'd0, tx, busy, done,
                         (m < 40) ? fifo_rd : 1'b0},
                        {28'd0, etx, 1'(m < 40),
                         1'(m == 40), 1'b0});
                    if (m >= 6 && m < 36 && (m % 4) == 2)
                        rx[(m-6)/4] = tx;
                    if (m == 40) begin
                        chk("rx_data", {24'd0, rx}, {24'd0, cur});
                        in_frame = 0;
                        ended = 1;
                    end else begin
                        m++;
                    end
                end
                if (!in_frame) begin
                    if (!ended)
                        chk("idle_line", {29'd0, tx, busy, done},
                            32'b100);
                    if (fifo_rd) begin
                        chk("pop_expected",
                            {31'd0, 1'(exp_q.size() > 0)}, 32'd1);
                        cur = (exp_q.size() > 0) ?
                              exp_q.pop_front() : 8'h00;
                        rx = '0;
                        m = 0;
                        in_frame = 1;
                        npops++;
                        pop_q.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        int bcnt, dat, dcnt, dhi, slo, shi;
        rst = 1;
        frst = 1;
        wr = 0;
        wdata = 0;
        empty2 = 1;
        data2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, tx, busy, done, fifo_rd},
            32'b1000);
        chk("reset_state2", {29'd0, tx2, busy2, done2}, 32'b100);
        rst = 0;
        frst = 0;

        // empty FIFO: monitor checks idle line each cycle
        repeat (50) @(posedge clk);
        #1;
        chk("no_pop_empty", npops, 0);

        push(8'h55);
        wait_idle();

        push(8'hAA);
        push(8'h0F);
        wait_idle();
        chk("b2b_gap", pop_q[$] - pop_q[$-1], 41);

        // abort mid-frame during data bit 3
        push(8'h33);
        @(posedge clk);
        #1;
        repeat (17) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("abort_line", {29'd0, tx, busy, fifo_rd}, 32'b100);
        push(8'hC3);
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("first_pop", {31'd0, fifo_rd}, 32'd1);
        wait_idle();

        // burst of four while busy fills the 4-deep FIFO
        push(8'h12);
        @(posedge clk);
        #1;
        push(8'h34);
        push(8'h56);
        push(8'h78);
        push(8'h9A);
        chk("fifo_full", {31'd0, ffull}, 32'd1);
        wait_idle();
        chk("fifo_empty_end", {31'd0, fifo_empty}, 32'd1);
        chk("pop_count", npops, npush);
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_pop", npops, npush);

        // two stop bits, word 0xFF
        empty2 = 0;
        data2 = 8'hFF;
        #1;
        chk("rd2_pulse", {31'd0, rd2}, 32'd1);
        @(posedge clk);
        #1;
        empty2 = 1;
        data2 = 8'h00;
        bcnt = 0;
        dat = -1;
        dcnt = 0;
        dhi = 0;
        slo = 0;
        shi = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy2) bcnt++;
            if (done2) begin
                dcnt++;
                if (dat < 0) dat = k;
            end
            if (k < 4 && !tx2) slo++;
            if (k >= 4 && k < 36 && tx2) dhi++;
            if (k >= 36 && k < 44 && tx2) shi++;
            if (rd2) dcnt += 100;
        end
        chk("s2_busy_cycles", bcnt, 44);
        chk("s2_done_at", dat, 44);
        chk("s2_done_count", dcnt, 1);
        chk("s2_start_low", slo, 4);
        chk("s2_data_high", dhi, 32);
        chk("s2_stop_high", shi, 8);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
